// File: rtl/uart_rx_if.sv
// Serial-side bundle of the UART receiver: line in, baud select in, byte and strobes out.
// The receiver takes the slave modport; whoever drives the line and consumes bytes takes master.
interface uart_rx_if;
   logic [2:0] baud_rate_select;
   logic       Rx_Serial;
   logic       Rx_Active;
   logic [7:0] Rx_Byte;
   logic       Rx_Done;
   logic       Framing_Error;

   modport master (
      output baud_rate_select,
      output Rx_Serial,
      input  Rx_Active,
      input  Rx_Byte,
      input  Rx_Done,
      input  Framing_Error
   );

   modport slave (
      input  baud_rate_select,
      input  Rx_Serial,
      output Rx_Active,
      output Rx_Byte,
      output Rx_Done,
      output Framing_Error
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error pulse and break absorption.
// Baud period is chosen per frame from the same 3-bit table as the team's transmitter.
module uart_rx (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      RX_START_BIT,
      RX_DATA_BITS,
      RX_STOP_BIT,
      CLEANUP
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        rx_meta;
   logic        rx_s;
   logic [10:0] bit_period;
   logic [10:0] half_period;
   logic [10:0] clk_count;
   logic [2:0]  bit_index;
   logic [7:0]  shift;
   logic [7:0]  byte_reg;
   logic        done_reg;
   logic        error_reg;
   logic        half_tick;
   logic        bit_tick;

   function automatic logic [10:0] baud_lookup(input logic [2:0] sel);
      logic [10:0] n;
      case (sel)
         3'b000:  n = 11'd1042;
         3'b001:  n = 11'd695;
         3'b010:  n = 11'd521;
         3'b011:  n = 11'd261;
         3'b100:  n = 11'd174;
         3'b101:  n = 11'd87;
         3'b110:  n = 11'd79;
         default: n = 11'd39;
      endcase
      return n;
   endfunction

   // The line is idle-high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.Rx_Serial;
         rx_s    <= rx_meta;
      end
   end

   assign half_period = bit_period >> 1;
   assign half_tick   = (clk_count >= (half_period - 11'd1));
   assign bit_tick    = (clk_count >= (bit_period - 11'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = RX_START_BIT;
            end
         end
         RX_START_BIT: begin
            if (half_tick) begin
               state_next = rx_s ? IDLE : RX_DATA_BITS;
            end
         end
         RX_DATA_BITS: begin
            if (bit_tick && (bit_index == 3'd7)) begin
               state_next = RX_STOP_BIT;
            end
         end
         RX_STOP_BIT: begin
            if (bit_tick) begin
               state_next = CLEANUP;
            end
         end
         CLEANUP: begin
            // A low line here is a break; hold off new frames until it releases.
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_period <= 11'd0;
         clk_count  <= 11'd0;
         bit_index  <= 3'd0;
         shift      <= 8'h00;
         byte_reg   <= 8'h00;
         done_reg   <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         unique case (state)
            IDLE: begin
               clk_count <= 11'd0;
               bit_index <= 3'd0;
               if (!rx_s) begin
                  bit_period <= baud_lookup(bus.baud_rate_select);
               end
            end
            RX_START_BIT: begin
               bit_index <= 3'd0;
               if (!half_tick) begin
                  clk_count <= clk_count + 11'd1;
               end else begin
                  clk_count <= 11'd0;
               end
            end
            RX_DATA_BITS: begin
               if (!bit_tick) begin
                  clk_count <= clk_count + 11'd1;
               end else begin
                  clk_count        <= 11'd0;
                  shift[bit_index] <= rx_s;
                  bit_index        <= (bit_index == 3'd7) ? 3'd0 : bit_index + 3'd1;
               end
            end
            RX_STOP_BIT: begin
               // The half-bit offset from the start bit puts this sample at mid-stop.
               if (!bit_tick) begin
                  clk_count <= clk_count + 11'd1;
               end else begin
                  clk_count <= 11'd0;
                  if (rx_s) begin
                     byte_reg <= shift;
                     done_reg <= 1'b1;
                  end else begin
                     error_reg <= 1'b1;
                  end
               end
            end
            CLEANUP: begin
               clk_count <= 11'd0;
               bit_index <= 3'd0;
            end
            default: begin
               clk_count <= 11'd0;
               bit_index <= 3'd0;
            end
         endcase
      end
   end

   always_comb begin
      bus.Rx_Active     = (state != IDLE);
      bus.Rx_Byte       = byte_reg;
      bus.Rx_Done       = done_reg;
      bus.Framing_Error = error_reg;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) arrive on a single asynchronous serial line; each byte is presented on a parallel output with a one-cycle done strobe.
- Uses the same 3-bit baud-select table as the team's UART transmitter, so both ends of a link configure identically.
- Sits between the board RX pin and the byte-level consumer (command parser or FIFO). Framing errors are flagged, and break conditions are absorbed.

Parameters:
- None. Baud timing comes from the baud_rate_select input.

Ports:
- clk  input  1  system clock. Single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- baud_rate_select  input  3  clocks-per-bit select. 000=1042, 001=695, 010=521, 011=261, 100=174, 101=87, 110=79, 111=39.
- Rx_Serial  input  1  asynchronous serial line. Idle high.
- Rx_Active  output  1  high from start-bit detection until return to IDLE.
- Rx_Byte  output  8  last correctly framed byte. Holds until the next good frame.
- Rx_Done  output  1  one-cycle pulse; Rx_Byte is valid in the same cycle.
- Framing_Error  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State=IDLE.
  - Both synchronizer flops=1.
  - Rx_Byte=8'h00, Rx_Done=0, Framing_Error=0, Rx_Active=0.
  - Counters and shift register cleared.
  - rst mid-frame abandons the frame; no Rx_Done or Framing_Error is produced.
- Synchronizer: two flops. All FSM decisions use the second flop (rx_s), giving 2 cycles of input latency.
- Bit timing:
  - N = table value for baud_rate_select, latched into an 11-bit register on start detection.
  - Changing baud_rate_select mid-frame has no effect until the next frame.
  - H = N >> 1 (floor).
- IDLE:
  - Rx_Active=0 and clk_count=0.
  - rx_s==0 -> latch N, go to RX_START_BIT, Rx_Active=1.
- RX_START_BIT:
  - While clk_count < H-1, increment.
  - Otherwise sample rx_s. If 0, set clk_count=0 and bit_index=0, go to RX_DATA_BITS.
  - If 1 (glitch), go to IDLE with no outputs.
- RX_DATA_BITS:
  - While clk_count < N-1, increment.
  - Otherwise set clk_count=0 and write shift[bit_index] <= rx_s.
  - If bit_index==7, set bit_index=0 and go to RX_STOP_BIT. Otherwise increment bit_index.
  - Each sample lands at mid-bit.
- RX_STOP_BIT:
  - While clk_count < N-1, increment.
  - Otherwise sample rx_s:
    - 1 -> Rx_Byte <= shift, Rx_Done=1 for this cycle only.
    - 0 -> Framing_Error=1 for one cycle; Rx_Byte is unchanged.
  - Go to CLEANUP.
- CLEANUP:
  - Rx_Done and Framing_Error return to 0.
  - If rx_s==1, go to IDLE and drop Rx_Active.
  - If rx_s==0 (break or line stuck low), stay in CLEANUP until rx_s==1. No new frame starts during a break.
- Latency:
  - Line falls before edge k -> Rx_Done/Framing_Error high after edge k+2+H+9N.
  - Example: N=39 gives 372 cycles.
  - The FSM is back in IDLE at the midpoint of the stop bit, so back-to-back frames with a single stop bit are received without loss.
- Rx_Done and Framing_Error are never high in the same cycle.

Test Plan:
- sel=111, send 8'hA5 (8N1 at 39 clk/bit) -> Rx_Done one cycle high 372 cycles after the start edge, Rx_Byte=8'hA5, Framing_Error=0.
- sel=101, back-to-back 8'h00, 8'hFF, 8'h3C with no idle gap -> three Rx_Done pulses exactly 870 cycles apart, bytes in order.
- sel=111, 10-cycle low glitch on the idle line -> no Rx_Done, Rx_Active high then back to 0 within 20 cycles, Rx_Byte unchanged.
- sel=111, send 8'h55 with stop bit forced low, then 8'h81 normally after the line returns high -> Framing_Error pulse, Rx_Byte stays at its prior value, then Rx_Byte=8'h81 with Rx_Done.
- Hold the line low for 2000 cycles (break), then release and send 8'h7E -> single Framing_Error, no further outputs during the break, 8'h7E received correctly.
- Assert rst for 1 cycle during data bit 4 of a frame, then send 8'hC3 -> no strobe for the aborted frame, Rx_Byte=8'h00 after reset, then 8'hC3 received. Also change sel mid-frame -> current frame still decoded at the latched rate.
